// File: rtl/sigmul_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sigmul_iter : iterative handshaked significand multiplier, RADIX_BITS    |
// | multiplier bits per clock. Optional macro: SIGMUL_EARLY_EXIT_EN.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sigmul_iter #(
  parameter int NSIG       = 10,
  parameter int RADIX_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NSIG:0]        a,
  input  logic [NSIG:0]        b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*NSIG+1:0]    p
);

  localparam int W     = NSIG + 1;
  localparam int PW    = 2 * NSIG + 2;
  // Clamped radix keeps elaboration sane even when the configuration is rejected.
  localparam int RB    = (RADIX_BITS < 1) ? 1 : ((RADIX_BITS > W) ? W : RADIX_BITS);
  localparam int NSTEP = (W + RB - 1) / RB;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(NSTEP - 1);

  if (RADIX_BITS < 1 || RADIX_BITS > W) begin : g_bad_radix
    $error("sigmul_iter: RADIX_BITS must lie in 1..NSIG+1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   count_q, count_d;
  logic            out_valid_q, out_valid_d;

  logic [PW-1:0]   pp;
  logic [W-1:0]    b_shift;
  logic            last_step;

  // Partial product of the current radix digit, aligned to its weight.
  assign pp      = (PW'(a_q) * PW'(b_q[RB-1:0])) << (count_q * RB);
  assign b_shift = b_q >> RB;

`ifdef SIGMUL_EARLY_EXIT_EN
  assign last_step = (count_q == C_LAST) || (b_shift == '0);
`else
  assign last_step = (count_q == C_LAST);
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          count_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d   = acc_q + pp;
        b_d     = b_shift;
        count_d = count_q + CW'(1);
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign p         = acc_q;

endmodule
`default_nettype wire
